// File: rtl/camera_stream_if.sv
// Pixel-stream handshake bundle between the camera source and its consumer.
interface camera_stream_if #(
  parameter int DATA_W = 8
);
  logic              data_valid;
  logic              data_ready;
  logic [DATA_W-1:0] data_out;
  logic              sof;
  logic              eol;
  logic              eof;

  modport master (output data_valid, data_out, sof, eol, eof, input data_ready);
  modport slave  (input data_valid, data_out, sof, eol, eof, output data_ready);
endinterface

// File: rtl/camera_stream.sv
// Camera pixel-stream source: FRAME_W x FRAME_H frames with sof/eol/eof
// markers, horizontal blanking, and table / ramp / frame-counter data modes.
// Output registers always hold the pixel currently offered downstream.
module camera_stream #(
  parameter int DATA_W  = 8,
  parameter int FRAME_W = 4,
  parameter int FRAME_H = 3,
  parameter int H_BLANK = 2,
  parameter int DEPTH   = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            camera_en,
  input  logic [1:0]      mode,
  output logic            busy,
  camera_stream_if.master st
);
  localparam int XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam int PW = (DEPTH   > 1) ? $clog2(DEPTH)   : 1;
  localparam int BW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);
  localparam logic [PW-1:0] P_LAST = PW'(DEPTH - 1);
  localparam logic [BW-1:0] B_LAST = BW'(H_BLANK - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK} state_t;

  state_t            state, state_n;
  logic [XW-1:0]     x, x_n;
  logic [YW-1:0]     y, y_n;
  logic [PW-1:0]     ptr, ptr_n;
  logic [BW-1:0]     bcnt, bcnt_n;
  logic [DATA_W-1:0] fcnt, fcnt_n;
  logic [1:0]        mode_q, mode_n;
  logic              load, clear;

  logic              vld_q, vld_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic              sof_q, sof_n, eol_q, eol_n, eof_q, eof_n;
  logic              busy_q, busy_n;

  // Pattern table; entries past the fixed 12 hold their own index.
  function automatic logic [DATA_W-1:0] tbl_val(input logic [PW-1:0] idx);
    logic [15:0] v;
    case (32'(idx))
      0:       v = 16'h00BC;
      1:       v = 16'h0027;
      2:       v = 16'h0081;
      3:       v = 16'h00FF;
      4:       v = 16'h00CE;
      5:       v = 16'h001F;
      6:       v = 16'h00E0;
      7:       v = 16'h00A9;
      8:       v = 16'h0038;
      9:       v = 16'h002B;
      10:      v = 16'h00D4;
      11:      v = 16'h0011;
      default: v = 16'(idx);
    endcase
    return v[DATA_W-1:0];
  endfunction

  // Next-state, position/pointer advance and next output pixel.
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    ptr_n   = ptr;
    bcnt_n  = bcnt;
    fcnt_n  = fcnt;
    mode_n  = mode_q;
    load    = 1'b0;
    clear   = 1'b0;

    case (state)
      IDLE: begin
        if (camera_en) begin
          state_n = ACTIVE;
          mode_n  = mode;
          x_n     = '0;
          y_n     = '0;
          ptr_n   = '0;
          load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (vld_q && st.data_ready) begin
          ptr_n = (ptr == P_LAST) ? '0 : ptr + PW'(1);
          if (x != X_LAST) begin
            x_n  = x + XW'(1);
            load = 1'b1;
          end else if (y != Y_LAST) begin
            // position moves to the next line now; blanking only delays the load
            x_n = '0;
            y_n = y + YW'(1);
            if (H_BLANK == 0) begin
              load = 1'b1;
            end else begin
              state_n = HBLANK;
              bcnt_n  = '0;
              clear   = 1'b1;
            end
          end else begin
            fcnt_n = fcnt + DATA_W'(1);
            x_n    = '0;
            y_n    = '0;
            ptr_n  = '0;
            if (camera_en) begin
              mode_n = mode;
              load   = 1'b1;
            end else begin
              state_n = IDLE;
              clear   = 1'b1;
            end
          end
        end
      end
      HBLANK: begin
        if (bcnt == B_LAST) begin
          state_n = ACTIVE;
          load    = 1'b1;
        end else begin
          bcnt_n = bcnt + BW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        clear   = 1'b1;
      end
    endcase

    vld_n  = vld_q;
    data_n = data_q;
    sof_n  = sof_q;
    eol_n  = eol_q;
    eof_n  = eof_q;
    if (load) begin
      vld_n = 1'b1;
      case (mode_n)
        2'd1:    data_n = DATA_W'(32'(x_n) + 32'(y_n));
        2'd2:    data_n = fcnt_n;
        default: data_n = tbl_val(ptr_n);
      endcase
      sof_n = (x_n == '0) && (y_n == '0);
      eol_n = (x_n == X_LAST);
      eof_n = (x_n == X_LAST) && (y_n == Y_LAST);
    end else if (clear) begin
      vld_n  = 1'b0;
      data_n = '0;
      sof_n  = 1'b0;
      eol_n  = 1'b0;
      eof_n  = 1'b0;
    end
    busy_n = (state_n != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      ptr    <= '0;
      bcnt   <= '0;
      fcnt   <= '0;
      mode_q <= '0;
      vld_q  <= 1'b0;
      data_q <= '0;
      sof_q  <= 1'b0;
      eol_q  <= 1'b0;
      eof_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      x      <= x_n;
      y      <= y_n;
      ptr    <= ptr_n;
      bcnt   <= bcnt_n;
      fcnt   <= fcnt_n;
      mode_q <= mode_n;
      vld_q  <= vld_n;
      data_q <= data_n;
      sof_q  <= sof_n;
      eol_q  <= eol_n;
      eof_q  <= eof_n;
      busy_q <= busy_n;
    end
  end

  assign st.data_valid = vld_q;
  assign st.data_out   = data_q;
  assign st.sof        = sof_q;
  assign st.eol        = eol_q;
  assign st.eof        = eof_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_camera_stream.sv
// Bench for camera_stream: frame-level reference model feeds a scoreboard,
// a negedge monitor compares every transferred pixel and handshake rule.
module tb_camera_stream;
  localparam int DW = 8, W = 4, H = 3, HB = 2, NPIX = W * H;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       camera_en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       busy;
  logic       en2 = 1'b0;
  logic [1:0] mode2 = 2'd0;
  logic       busy2;

  camera_stream_if #(.DATA_W(DW)) sif ();
  camera_stream_if #(.DATA_W(DW)) sif2 ();

  camera_stream #(.DATA_W(DW), .FRAME_W(W), .FRAME_H(H), .H_BLANK(HB), .DEPTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .camera_en(camera_en), .mode(mode), .busy(busy), .st(sif.master));

  camera_stream #(.DATA_W(DW), .FRAME_W(4), .FRAME_H(2), .H_BLANK(2), .DEPTH(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .camera_en(en2), .mode(mode2), .busy(busy2), .st(sif2.master));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  pix_t exp_q[$];
  int xfer_cnt = 0;
  int fidx = 0;
  bit rnd_ready = 1'b0;
  bit [7:0] tbl [12] = '{8'hBC, 8'h27, 8'h81, 8'hFF, 8'hCE, 8'h1F,
                         8'hE0, 8'hA9, 8'h38, 8'h2B, 8'hD4, 8'h11};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    checks++;
    failures++;
    $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: expected pixels of n whole frames in mode m.
  task automatic push_frames(input logic [1:0] m, input int n);
    pix_t e;
    int x, y;
    for (int f = 0; f < n; f++) begin
      for (int k = 0; k < NPIX; k++) begin
        x = k % W;
        y = k / W;
        case (m)
          2'd1:    e.data = 8'(x + y);
          2'd2:    e.data = 8'(fidx);
          default: e.data = tbl[k % 12];
        endcase
        e.sof = (k == 0);
        e.eol = (x == W - 1);
        e.eof = (k == NPIX - 1);
        exp_q.push_back(e);
      end
      fidx++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sif.data_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  // Run n frames; camera_en drops after the 3rd pixel of the last frame.
  task automatic run_frames(input logic [1:0] m, input int n, input bit stall81);
    int base, guard;
    bit stalled;
    stalled = 1'b0;
    mode = m;
    push_frames(m, n);
    base = xfer_cnt;
    camera_en = 1'b1;
    step();
    check("start_valid", 32'(sif.data_valid), 32'd1);
    check("start_sof", 32'(sif.sof), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    if (n == 1) mode = m + 2'($urandom_range(1, 3));
    guard = 0;
    while (xfer_cnt < base + (n - 1) * NPIX + 3 && guard < 100 * n) begin
      step();
      guard++;
      if (stall81 && !stalled && sif.data_valid && sif.data_out == 8'h81) begin
        stalled = 1'b1;
        sif.data_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          step();
          check("stall81_valid", 32'(sif.data_valid), 32'd1);
          check("stall81_data", 32'(sif.data_out), 32'h81);
          if (i < 4) sif.data_ready = 1'b0;
        end
      end
    end
    if (guard >= 100 * n) fail_now("timeout_xfer", xfer_cnt - base, (n - 1) * NPIX + 3);
    if (stall81 && !stalled) fail_now("stall81_seen", 0, 1);
    camera_en = 1'b0;
    guard = 0;
    while (busy && guard < 200) begin
      step();
      guard++;
    end
    if (busy) fail_now("timeout_idle", guard, 200);
    step();
    step();
  endtask

  // Monitor: scoreboard pops, stall stability, blanking length, frame end.
  initial begin : monitor
    pix_t cur, e, snap;
    bit in_gap, eof_pend, en_at, stall_pend;
    int gap;
    in_gap = 0; eof_pend = 0; en_at = 0; stall_pend = 0; gap = 0; snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_gap = 0;
        eof_pend = 0;
        stall_pend = 0;
      end else begin
        cur = '{sif.data_out, sif.sof, sif.eol, sif.eof};
        if (stall_pend) begin
          check("stall_valid", 32'(sif.data_valid), 32'd1);
          check("stall_hold", 32'(cur), 32'(snap));
          stall_pend = 0;
        end
        if (eof_pend) begin
          check("post_eof_busy", 32'(busy), 32'(en_at));
          check("post_eof_valid", 32'(sif.data_valid), 32'(en_at));
          if (en_at) check("b2b_sof", 32'(sif.sof), 32'd1);
          eof_pend = 0;
        end
        if (in_gap) begin
          if (!sif.data_valid) gap++;
          else begin
            check("hblank_len", 32'(gap), 32'(HB));
            in_gap = 0;
          end
        end
        if (!sif.data_valid) begin
          check("idle_zero", 32'(cur), 32'd0);
        end else if (sif.data_ready) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pixel: got %0h expected none at %0t", cur, $time);
          end else begin
            e = exp_q.pop_front();
            check("pixel", 32'(cur), 32'(e));
          end
          if (cur.eol && !cur.eof) begin
            in_gap = 1;
            gap = 0;
          end
          if (cur.eof) begin
            eof_pend = 1;
            en_at = camera_en;
          end
        end else begin
          stall_pend = 1;
          snap = cur;
        end
      end
    end
  end

  // Small instance: DEPTH=5, two lines; pointer wraps across the line break.
  initial begin : small_dut
    bit [7:0] exp2 [8];
    int got, guard;
    exp2 = '{8'hBC, 8'h27, 8'h81, 8'hFF, 8'hCE, 8'hBC, 8'h27, 8'h81};
    got = 0;
    guard = 0;
    sif2.data_ready = 1'b1;
    wait (rst_n === 1'b0);
    wait (rst_n === 1'b1);
    @(posedge clk); #1 en2 = 1'b1;
    @(posedge clk); #1 en2 = 1'b0;
    while (got < 8 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (sif2.data_valid) begin
        check("depth5_pixel", 32'(sif2.data_out), 32'(exp2[got]));
        check("depth5_eof", 32'(sif2.eof), 32'(got == 7));
        got++;
      end
    end
    if (got < 8) fail_now("depth5_timeout", got, 8);
  end

  initial begin : stimulus
    int base, guard;
    sif.data_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", 32'(sif.data_valid), 32'd0);
    check("rst_data", 32'(sif.data_out), 32'd0);
    check("rst_flags", 32'({sif.sof, sif.eol, sif.eof}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    run_frames(2'd0, 2, 1'b0);
    run_frames(2'd1, 1, 1'b0);
    run_frames(2'd2, 2, 1'b0);
    run_frames(2'd0, 1, 1'b1);

    rnd_ready = 1'b1;
    for (int r = 0; r < 6; r++)
      run_frames(2'($urandom_range(0, 3)), $urandom_range(1, 3), 1'b0);
    rnd_ready = 1'b0;

    // Reset in the middle of the second line.
    mode = 2'd0;
    push_frames(2'd0, 1);
    base = xfer_cnt;
    camera_en = 1'b1;
    step();
    guard = 0;
    while (xfer_cnt < base + 5 && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) fail_now("timeout_midframe", xfer_cnt - base, 5);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(sif.data_valid), 32'd0);
    check("async_rst_data", 32'(sif.data_out), 32'd0);
    check("async_rst_flags", 32'({sif.sof, sif.eol, sif.eof}), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    fidx = 0;
    camera_en = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    run_frames(2'd2, 1, 1'b0);
    run_frames(2'd2, 258, 1'b0);

    step(); step(); step(); step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/camera_stream.md
# camera_stream

Parametrised camera pixel-stream source that supersedes the fixed 12-byte camera model. It emits frames of FRAME_W x FRAME_H pixels with a valid/ready handshake, start-of-frame, end-of-line and end-of-frame markers, and programmable horizontal blanking. It offers three data modes: pattern-table, ramp and frame counter. It sits at the head of the image pipeline and drives the capture/buffer logic downstream.

## Interface
- DATA_W, 8: pixel width in bits (1..16)
- FRAME_W, 4: pixels per line (>=1)
- FRAME_H, 3: lines per frame (>=1)
- H_BLANK, 2: idle cycles after each line's last pixel (>=0)
- DEPTH, 12: pattern-table entries (>=1)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- camera_en  in  1  stream enable, level sensitive
- mode  in  2  data mode: 0 pattern table, 1 ramp, 2 frame counter, 3 reserved (behaves as 0)
- data_ready  in  1  downstream accepts the current pixel
- data_valid  out  1  data_out holds a pixel
- data_out  out  DATA_W  pixel value
- sof  out  1  current pixel is (x=0, y=0)
- eol  out  1  current pixel is x=FRAME_W-1
- eof  out  1  current pixel is the frame's last pixel
- busy  out  1  frame in progress (ACTIVE or HBLANK)

## Operation
- States: IDLE, ACTIVE, HBLANK.
- IDLE -> ACTIVE:
  - Transition occurs on the clock edge where camera_en=1.
  - On that edge, mode is latched into mode_q for the whole frame, x=y=0, and tbl_ptr=0.
  - The first pixel is presented at the same edge.
- ACTIVE: a pixel is transferred on each edge with data_valid & data_ready. On transfer, x, tbl_ptr and the next pixel advance.
  - x==FRAME_W-1 and y<FRAME_H-1: go to HBLANK, or straight to ACTIVE on the next line if H_BLANK=0.
  - Last pixel of the frame: frame_cnt increments (wraps at 2^DATA_W). Then:
    - camera_en=1: start the next frame back-to-back, re-latching mode.
    - camera_en=0: go to IDLE.
- HBLANK: data_valid=0 for exactly H_BLANK cycles, then ACTIVE with x=0 and y+1.
- camera_en=0 mid-frame is ignored. The frame always completes, so no partial frames are produced.
- Pixel value by latched mode:
  - 0 (and 3): TABLE[tbl_ptr]. tbl_ptr wraps from DEPTH-1 to 0, runs continuously across lines, and is cleared at each frame start.
  - 1: (x + y) truncated to DATA_W.
  - 2: frame_cnt (frame index, constant within a frame).
- TABLE default contents for entries 0..11: BC 27 81 FF CE 1F E0 A9 38 2B D4 11, truncated to DATA_W. Entries >=12 hold index[DATA_W-1:0].
- data_out is 0 whenever data_valid=0. No tri-state output.

## Timing
- Reset values: data_valid=0, data_out=0, sof=0, eol=0, eof=0, busy=0, state IDLE, x=y=tbl_ptr=frame_cnt=0.
- All outputs are registered. Latency from camera_en sampled high in IDLE to first data_valid is 1 edge.
- Handshake rules:
  - With data_valid=1 and data_ready=0, data_out, sof, eol and eof hold stable. The stall is unbounded.
  - data_valid never deasserts without a transfer.
- sof, eol and eof are qualified by data_valid and hold with the stalled pixel.
- FRAME_W=1: every pixel has eol=1. FRAME_H=1: eof coincides with eol.
- Minimum frame period with data_ready=1: FRAME_H*FRAME_W + (FRAME_H-1)*H_BLANK cycles. No blanking after the last line; the next frame starts on the following edge.
- rst_n low mid-frame: all outputs clear immediately (asynchronously), frame_cnt clears, and no frame is resumed.
- A mode change mid-frame takes effect only at the next frame start.

## Test plan
- Defaults, mode 0, camera_en=1, data_ready=1:
  - Pixels BC 27 81 FF | CE 1F E0 A9 | 38 2B D4 11.
  - sof on BC. eol on FF, A9, 11. eof on 11.
  - 2 invalid cycles after FF and after A9.
  - Next frame restarts at BC.
- DEPTH=5, FRAME_W=4, FRAME_H=2, mode 0: pixels BC 27 81 FF CE BC 27 81 (pointer wraps across the line break).
- Mode 1 with defaults: pixels 0 1 2 3 | 1 2 3 4 | 2 3 4 5. Mode 2: frame 0 all 00, frame 1 all 01, frame 255 followed by frame 00.
- Backpressure:
  - data_ready low for 5 cycles on pixel 81: data_out=81 and data_valid=1 held for all 5 cycles.
  - No pixel lost or duplicated.
  - Frame contents identical to the unstalled run.
- camera_en dropped after the 3rd pixel: the frame completes all 12 pixels with eof, then IDLE, with busy=0 the cycle after eof transfers.
- rst_n pulsed low during the 2nd line: outputs go to 0 immediately. After release with camera_en=1, output restarts at BC with sof, and mode 2 shows frame_cnt=00.
